// File: rtl/signed_divider.sv
// signed_divider: 32-bit signed restoring divider, 34-cycle fixed latency
//   clock, reset (sync, active-high)
//   ctrl_DIV        start pulse, operands sampled in the same cycle
//   data_operandA   dividend, two's complement
//   data_operandB   divisor, two's complement
//   data_result     quotient truncated toward zero, held until next completion
//   data_exception  divide-by-zero or INT_MIN/-1 overflow, held with data_result
//   data_resultRDY  one-cycle done pulse
module signed_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;
    state_t state, next;
    logic [5:0]  cnt;
    logic [31:0] q, mag_b;
    // Partial remainder always stays below mag_b <= 2^31, so its 33rd bit is
    // structurally zero and only the low 32 bits are stored.
    logic [31:0] r;
    logic [32:0] t, d;
    logic        neg, dz, ovf;
    always_comb begin
        t    = {r, q[31]};
        d    = t - {1'b0, mag_b};
        next = ctrl_DIV ? RUN : state == RUN ? (cnt == 6'd31 ? FIXUP : RUN) : IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt            <= '0;
            r              <= '0;
            q              <= '0;
            mag_b          <= '0;
            neg            <= 1'b0;
            dz             <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_DIV) begin
                cnt   <= '0;
                r     <= '0;
                q     <= data_operandA[31] ? ~data_operandA + 32'd1 : data_operandA;
                mag_b <= data_operandB[31] ? ~data_operandB + 32'd1 : data_operandB;
                neg   <= data_operandA[31] ^ data_operandB[31];
                dz    <= data_operandB == 32'd0;
                ovf   <= data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF;
            end else if (state == RUN) begin
                r   <= d[32] ? t[31:0] : d[31:0];
                q   <= {q[30:0], ~d[32]};
                cnt <= cnt + 6'd1;
            end else if (state == FIXUP) begin
                data_result    <= dz ? 32'd0 : ovf ? 32'h8000_0000 : neg ? ~q + 32'd1 : q;
                data_exception <= dz | ovf;
                data_resultRDY <= 1'b1;
            end
        end
    end
endmodule
